// File: rtl/rob_gen_if.sv
// rob_gen_if: dispatch/complete/commit bundle for rob_gen; ROB_EARLY_RECOVER_EN adds the recover_* signals
interface rob_gen_if #(
  parameter int DEPTH      = 32,
  parameter int DISPATCH_W = 2,
  parameter int COMPLETE_W = 2,
  parameter int COMMIT_W   = 2,
  parameter int PAYLOAD_W  = 64,
  parameter int PTR_W      = $clog2(DEPTH),
  parameter int CNT_W      = $clog2(DEPTH + 1)
);
  logic [DISPATCH_W-1:0]           dispatch_valid;
  logic [DISPATCH_W*PAYLOAD_W-1:0] dispatch_payload;
  logic                            dispatch_ready;
  logic [DISPATCH_W*PTR_W-1:0]     alloc_robn;
  logic [COMPLETE_W-1:0]           complete_valid;
  logic [COMPLETE_W*PTR_W-1:0]     complete_robn;
  logic [COMPLETE_W-1:0]           complete_mispredict;
  logic [COMMIT_W-1:0]             commit_valid;
  logic [COMMIT_W*PAYLOAD_W-1:0]   commit_payload;
  logic [COMMIT_W-1:0]             commit_mispredict;
  logic                            squash;
  logic [CNT_W-1:0]                count;
  logic [PTR_W-1:0]                head;
  logic [PTR_W-1:0]                tail;
`ifdef ROB_EARLY_RECOVER_EN
  logic                            recover_valid;
  logic [PTR_W-1:0]                recover_robn;
`endif
  modport master (
    output dispatch_valid, dispatch_payload, complete_valid, complete_robn, complete_mispredict,
    input  dispatch_ready, alloc_robn, commit_valid, commit_payload, commit_mispredict,
    input  squash, count, head, tail
`ifdef ROB_EARLY_RECOVER_EN
    , input recover_valid, recover_robn
`endif
  );
  modport slave (
    input  dispatch_valid, dispatch_payload, complete_valid, complete_robn, complete_mispredict,
    output dispatch_ready, alloc_robn, commit_valid, commit_payload, commit_mispredict,
    output squash, count, head, tail
`ifdef ROB_EARLY_RECOVER_EN
    , output recover_valid, recover_robn
`endif
  );
endinterface

// File: rtl/rob_gen.sv
// rob_gen: parametrised reorder buffer (any DEPTH >= 2); ROB_EARLY_RECOVER_EN enables tail rollback on mispredicted completion
module rob_gen #(
  parameter int DEPTH      = 32,
  parameter int DISPATCH_W = 2,
  parameter int COMPLETE_W = 2,
  parameter int COMMIT_W   = 2,
  parameter int PAYLOAD_W  = 64,
  parameter int PTR_W      = $clog2(DEPTH),
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input logic      clock,
  input logic      reset,
  rob_gen_if.slave io_rob
);
  logic [DEPTH-1:0]     r_valid, r_exec, r_misp;
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];
  logic [PTR_W-1:0]     r_head, r_tail;
  logic [CNT_W-1:0]     r_count;
  logic [PTR_W-1:0]     w_cidx [COMMIT_W];
  logic [PTR_W-1:0]     w_crn [COMPLETE_W];
  logic [COMPLETE_W-1:0] w_cok;
  logic [COMMIT_W-1:0]  w_commit;
  logic                 w_chain, w_squash, w_ready, w_dgo, w_rec;
  logic [PTR_W-1:0]     w_rec_robn;
  int                   w_ncommit, w_ndisp, w_rec_age;

  function automatic logic [PTR_W-1:0] f_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return PTR_W'(s >= DEPTH ? s - DEPTH : s);
  endfunction

  function automatic int f_age(input logic [PTR_W-1:0] p, input logic [PTR_W-1:0] h);
    return p >= h ? int'(p) - int'(h) : int'(p) + DEPTH - int'(h);
  endfunction

  assign w_ready               = DEPTH - int'(r_count) >= DISPATCH_W;
  assign w_dgo                 = w_ready && !w_rec;
  assign w_squash              = |io_rob.commit_mispredict;
  assign io_rob.dispatch_ready = w_ready;
  assign io_rob.commit_valid   = w_commit;
  assign io_rob.squash         = w_squash;
  assign io_rob.count          = r_count;
  assign io_rob.head           = r_head;
  assign io_rob.tail           = r_tail;

  // in-order commit group: stops at the first unexecuted entry, and a mispredict closes the group
  always_comb begin
    w_commit                 = '0;
    w_ncommit                = 0;
    w_chain                  = 1'b1;
    io_rob.commit_mispredict = '0;
    io_rob.commit_payload    = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      w_cidx[j]                = f_add(r_head, j);
      w_commit[j]              = w_chain && j < int'(r_count) && r_valid[w_cidx[j]] && r_exec[w_cidx[j]];
      w_chain                  = w_commit[j] && !r_misp[w_cidx[j]];
      io_rob.commit_mispredict[j] = w_commit[j] && r_misp[w_cidx[j]];
      io_rob.commit_payload[j*PAYLOAD_W +: PAYLOAD_W] = r_payload[w_cidx[j]];
      w_ncommit                = w_commit[j] ? j + 1 : w_ncommit;
    end
  end

  // allocation numbers follow the tail; accepted lanes counted only when dispatch is taken
  always_comb begin
    io_rob.alloc_robn = '0;
    w_ndisp           = 0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      io_rob.alloc_robn[i*PTR_W +: PTR_W] = f_add(r_tail, i);
      w_ndisp = w_ndisp + ((w_dgo && io_rob.dispatch_valid[i]) ? 1 : 0);
    end
  end

  // completions land only on live entries, never on ones younger than a rollback point
  always_comb begin
    for (int c = 0; c < COMPLETE_W; c++) begin
      w_crn[c] = io_rob.complete_robn[c*PTR_W +: PTR_W];
      w_cok[c] = io_rob.complete_valid[c] && r_valid[w_crn[c]] && (!w_rec || f_age(w_crn[c], r_head) <= w_rec_age);
    end
  end

`ifdef ROB_EARLY_RECOVER_EN
  // oldest mispredicted completion to a live entry picks the rollback point
  always_comb begin
    w_rec      = 1'b0;
    w_rec_robn = '0;
    w_rec_age  = DEPTH;
    for (int c = 0; c < COMPLETE_W; c++) begin
      if (io_rob.complete_valid[c] && io_rob.complete_mispredict[c] &&
          r_valid[io_rob.complete_robn[c*PTR_W +: PTR_W]] &&
          f_age(io_rob.complete_robn[c*PTR_W +: PTR_W], r_head) < w_rec_age) begin
        w_rec      = 1'b1;
        w_rec_robn = io_rob.complete_robn[c*PTR_W +: PTR_W];
        w_rec_age  = f_age(io_rob.complete_robn[c*PTR_W +: PTR_W], r_head);
      end
    end
  end

  logic             r_rec_valid;
  logic [PTR_W-1:0] r_rec_robn;
  assign io_rob.recover_valid = r_rec_valid;
  assign io_rob.recover_robn  = r_rec_robn;

  // one-cycle recovery pulse following the rollback edge
  always_ff @(posedge clock) begin
    r_rec_valid <= reset && !w_squash && w_rec;
    r_rec_robn  <= w_rec_robn;
  end
`else
  assign w_rec      = 1'b0;
  assign w_rec_robn = '0;
  assign w_rec_age  = 0;
`endif

  // entry state, pointers and occupancy; reset and commit-time squash both flush everything
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_valid <= '0;
      r_exec  <= '0;
      r_misp  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_squash) begin
      r_valid <= '0;
      r_count <= '0;
`ifdef ROB_EARLY_RECOVER_EN
      r_head  <= r_tail;
`else
      r_head  <= '0;
      r_tail  <= '0;
`endif
    end else begin
      for (int c = 0; c < COMPLETE_W; c++)
        if (w_cok[c]) begin
          r_exec[w_crn[c]] <= 1'b1;
          r_misp[w_crn[c]] <= r_misp[w_crn[c]] | io_rob.complete_mispredict[c];
        end
      for (int j = 0; j < COMMIT_W; j++)
        if (w_commit[j]) r_valid[w_cidx[j]] <= 1'b0;
      for (int e = 0; e < DEPTH; e++)
        if (w_rec && f_age(PTR_W'(e), r_head) > w_rec_age) r_valid[e] <= 1'b0;
      for (int i = 0; i < DISPATCH_W; i++)
        if (w_dgo && io_rob.dispatch_valid[i]) begin
          r_valid[f_add(r_tail, i)]   <= 1'b1;
          r_exec[f_add(r_tail, i)]    <= 1'b0;
          r_misp[f_add(r_tail, i)]    <= 1'b0;
          r_payload[f_add(r_tail, i)] <= io_rob.dispatch_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
      r_head  <= f_add(r_head, w_ncommit);
      r_tail  <= w_rec ? f_add(w_rec_robn, 1) : f_add(r_tail, w_ndisp);
      r_count <= w_rec ? CNT_W'(w_rec_age + 1 - w_ncommit) : CNT_W'(int'(r_count) + w_ndisp - w_ncommit);
    end
  end
endmodule

// File: tb/tb_rob_gen.sv
// tb_rob_gen: directed steps then random traffic, all checked against a queue model of the ROB
module tb_rob_gen;
  localparam int D  = 8;
  localparam int PW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  rob_gen_if #(.DEPTH(D), .DISPATCH_W(2), .COMPLETE_W(2), .COMMIT_W(2), .PAYLOAD_W(PW)) bus();
  rob_gen #(.DEPTH(D), .DISPATCH_W(2), .COMPLETE_W(2), .COMMIT_W(2), .PAYLOAD_W(PW)) dut (
    .clock(clock), .reset(reset), .io_rob(bus));

  typedef struct {int robn; logic [PW-1:0] pl; bit ex; bit mp;} ent_t;
  ent_t q[$];
  int mh = 0, mt = 0, n_cmp = 0, n_fail = 0, m_rec_r = 0;
  bit m_rec_v = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int find(input int r);
    foreach (q[i]) if (q[i].robn == r) return i;
    return -1;
  endfunction

  // check outputs against the model, apply one cycle of inputs, then advance the model
  task automatic cyc(input bit rn, input logic [1:0] dv, input logic [31:0] dp,
                     input logic [1:0] cv, input logic [5:0] crn, input logic [1:0] cm);
    int ncm, nd, rec, p;
    bit sq, rdy;
    logic [1:0] ecv, ecm;
    logic [31:0] epl, msk;
    ncm = 0; nd = 0; sq = 0; ecv = 0; ecm = 0; epl = 0;
    for (int k = 0; k < 2; k++) begin
      if (k >= q.size() || !q[k].ex) break;
      ecv[k] = 1'b1;
      ecm[k] = q[k].mp;
      epl[k*PW +: PW] = q[k].pl;
      ncm++;
      if (q[k].mp) begin sq = 1; break; end
    end
    rdy = (D - q.size()) >= 2;
    msk = {{PW{ecv[1]}}, {PW{ecv[0]}}};
    chk("count", bus.count, q.size());
    chk("head", bus.head, mh);
    chk("tail", bus.tail, mt);
    chk("ready", bus.dispatch_ready, rdy);
    chk("alloc", bus.alloc_robn, {3'((mt + 1) % D), 3'(mt)});
    chk("commit_valid", bus.commit_valid, ecv);
    chk("commit_misp", bus.commit_mispredict, ecm);
    chk("squash", bus.squash, sq);
    chk("commit_payload", bus.commit_payload & msk, epl);
`ifdef ROB_EARLY_RECOVER_EN
    chk("recover_valid", bus.recover_valid, m_rec_v);
    if (m_rec_v) chk("recover_robn", bus.recover_robn, m_rec_r);
`endif
    reset = rn;
    bus.dispatch_valid = dv;
    bus.dispatch_payload = dp;
    bus.complete_valid = cv;
    bus.complete_robn = crn;
    bus.complete_mispredict = cm;
    @(posedge clock);
    m_rec_v = 0;
    if (!rn || sq) begin
      q.delete();
`ifdef ROB_EARLY_RECOVER_EN
      mt = rn ? mt : 0;
      mh = mt;
`else
      mh = 0;
      mt = 0;
`endif
    end else begin
      rec = -1;
`ifdef ROB_EARLY_RECOVER_EN
      for (int c = 0; c < 2; c++)
        if (cv[c] && cm[c]) begin
          p = find(int'(crn[c*3 +: 3]));
          if (p >= 0 && (rec < 0 || p < rec)) rec = p;
        end
`endif
      for (int c = 0; c < 2; c++)
        if (cv[c]) begin
          p = find(int'(crn[c*3 +: 3]));
          if (p >= 0 && (rec < 0 || p <= rec)) begin
            q[p].ex = 1;
            q[p].mp = q[p].mp | cm[c];
          end
        end
      if (rec >= 0) begin
        m_rec_v = 1;
        m_rec_r = q[rec].robn;
        mt = (q[rec].robn + 1) % D;
        while (q.size() > rec + 1) void'(q.pop_back());
      end
      for (int k = 0; k < ncm; k++) void'(q.pop_front());
      mh = (mh + ncm) % D;
      if (rec < 0 && rdy) begin
        for (int i = 0; i < 2; i++)
          if (dv[i]) begin
            q.push_back('{(mt + i) % D, dp[i*PW +: PW], 1'b0, 1'b0});
            nd++;
          end
        mt = (mt + nd) % D;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle();
    cyc(1, 2'b00, 32'h0, 2'b00, 6'h0, 2'b00);
  endtask

  task automatic disp(input logic [1:0] dv);
    cyc(1, dv, $urandom, 2'b00, 6'h0, 2'b00);
  endtask

  task automatic comp(input logic [2:0] r1, input logic [2:0] r0, input logic [1:0] cv, input logic [1:0] cm);
    cyc(1, 2'b00, 32'h0, cv, {r1, r0}, cm);
  endtask

  initial begin
    int cand[$];
    int a, b, r;
    logic [1:0] dv, cv, cm;
    logic [5:0] crn;
    bus.dispatch_valid = 0;
    bus.dispatch_payload = 0;
    bus.complete_valid = 0;
    bus.complete_robn = 0;
    bus.complete_mispredict = 0;
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("rst_ready", bus.dispatch_ready, 1);
    chk("rst_count", bus.count, 0);
    chk("rst_commit", bus.commit_valid, 0);
    chk("rst_squash", bus.squash, 0);

    for (int i = 0; i < 4; i++) begin
      chk("s1_alloc", bus.alloc_robn, {3'(2 * i + 1), 3'(2 * i)});
      disp(2'b11);
    end
    chk("s1_full_count", bus.count, 8);
    chk("s1_full_ready", bus.dispatch_ready, 0);
    disp(2'b11);
    chk("s1_drop_tail", bus.tail, 0);
    chk("s1_drop_count", bus.count, 8);

    comp(3'd0, 3'd1, 2'b01, 2'b00);
    chk("s2_wait", bus.commit_valid, 0);
    comp(3'd0, 3'd0, 2'b01, 2'b00);
    chk("s2_commit", bus.commit_valid, 2'b11);
    idle();
    chk("s2_head", bus.head, 2);

    comp(3'd3, 3'd2, 2'b11, 2'b00);
    comp(3'd5, 3'd4, 2'b11, 2'b00);
    comp(3'd7, 3'd6, 2'b11, 2'b00);
    idle();
    idle();
    chk("s3_empty_commit", bus.commit_valid, 0);
    repeat (3) disp(2'b11);
    comp(3'd1, 3'd0, 2'b11, 2'b00);
    comp(3'd3, 3'd2, 2'b11, 2'b00);
    comp(3'd5, 3'd4, 2'b11, 2'b00);
    idle();
    idle();
    chk("s3_head6", bus.head, 6);
    chk("s3_tail6", bus.tail, 6);
    chk("s3_alloc_a", bus.alloc_robn, {3'd7, 3'd6});
    disp(2'b11);
    chk("s3_alloc_wrap", bus.alloc_robn, {3'd1, 3'd0});
    disp(2'b11);
    comp(3'd7, 3'd6, 2'b11, 2'b00);
    comp(3'd1, 3'd0, 2'b11, 2'b00);
    idle();
    idle();
    chk("s3_head2", bus.head, 2);
    chk("s3_count0", bus.count, 0);

    disp(2'b11);
    disp(2'b11);
    cyc(1, 2'b01, $urandom, 2'b11, {3'd3, 3'd2}, 2'b10);
    chk("s4_commit", bus.commit_valid, 2'b11);
    chk("s4_squash", bus.squash, 1);
    chk("s4_misp", bus.commit_mispredict, 2'b10);
    disp(2'b11);
    chk("s4_count", bus.count, 0);
`ifdef ROB_EARLY_RECOVER_EN
    chk("s4_head", bus.head, 4);
    chk("s4_tail", bus.tail, 4);
`else
    chk("s4_head", bus.head, 0);
    chk("s4_tail", bus.tail, 0);
`endif

    disp(2'b11);
    disp(2'b11);
    disp(2'b01);
    chk("s5_count5", bus.count, 5);
    cyc(0, 2'b11, $urandom, 2'b11, {3'(q[1].robn), 3'(q[0].robn)}, 2'b00);
    chk("s5_count", bus.count, 0);
    chk("s5_commit", bus.commit_valid, 0);
    chk("s5_ready", bus.dispatch_ready, 1);

`ifdef ROB_EARLY_RECOVER_EN
    repeat (3) disp(2'b11);
    comp(3'd2, 3'd4, 2'b11, 2'b11);
    chk("s6_tail", bus.tail, 3);
    chk("s6_count", bus.count, 3);
    chk("s6_rec_valid", bus.recover_valid, 1);
    chk("s6_rec_robn", bus.recover_robn, 2);
    comp(3'd0, 3'd4, 2'b01, 2'b00);
    chk("s6_ignored_count", bus.count, 3);
    chk("s6_ignored_tail", bus.tail, 3);
`endif

    for (int t = 0; t < 400; t++) begin
      cand.delete();
      foreach (q[i]) if (!q[i].ex) cand.push_back(q[i].robn);
      r  = int'($urandom_range(0, 3));
      dv = r == 0 ? 2'b00 : r == 1 ? 2'b01 : 2'b11;
      cv = 0; cm = 0; crn = 0;
      if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
        a = int'($urandom_range(0, cand.size() - 1));
        cv[0] = 1'b1;
        crn[2:0] = 3'(cand[a]);
        cm[0] = $urandom_range(0, 9) == 0;
        if (cand.size() > 1 && $urandom_range(0, 1) == 1) begin
          b = (a + 1 + int'($urandom_range(0, cand.size() - 2))) % cand.size();
          cv[1] = 1'b1;
          crn[5:3] = 3'(cand[b]);
          cm[1] = $urandom_range(0, 9) == 0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        r = int'($urandom_range(0, D - 1));
        if (find(r) < 0) begin
          cv[0] = 1'b1;
          crn[2:0] = 3'(r);
          cm[0] = $urandom_range(0, 1) == 1;
        end
      end
      cyc($urandom_range(0, 79) != 0, dv, $urandom, cv, crn, cm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
